st_pixel_unpacker: RTL and testbench



---
 rtl/st_pixel_unpacker_if.sv | 28 ++
 rtl/st_pixel_unpacker.sv | 107 ++++++++++
 tb/tb_st_pixel_unpacker.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/st_pixel_unpacker_if.sv
// Stream-in / pixel-out bundle for st_pixel_unpacker.
// The unpacker is the slave: it sinks stream words and sources tagged pixels.
interface st_pixel_unpacker_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] st_data;
  logic                  valid;
  logic                  ready;
  logic                  resync;
  logic [23:0]           pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sol;
  logic                  pix_eol;
  logic                  pix_sof;
  logic                  pix_eof;
  logic [15:0]           underrun_cnt;

  modport slave (
    input  st_data, valid, resync, pix_ready,
    output ready, pix_data, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, underrun_cnt
  );

  modport master (
    output st_data, valid, resync, pix_ready,
    input  ready, pix_data, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, underrun_cnt
  );
endinterface

// File: rtl/st_pixel_unpacker.sv
// Unpacks wide stream words into 24-bit RGB pixels, one per handshake,
// tagging line/frame boundaries and counting mid-frame starvation cycles.
module st_pixel_unpacker #(
  parameter int DATA_WIDTH = 256,
  parameter int SLOT_WIDTH = 32,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080
) (
  input logic                clk,
  input logic                rst_n,
  st_pixel_unpacker_if.slave bus
);

  localparam int NSLOT = DATA_WIDTH / SLOT_WIDTH;
  localparam int SW    = (NSLOT > 1)    ? $clog2(NSLOT)    : 1;
  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  if ((DATA_WIDTH % SLOT_WIDTH) != 0 || SLOT_WIDTH < 24) begin : g_bad_params
    $error("st_pixel_unpacker: DATA_WIDTH must be a multiple of SLOT_WIDTH >= 24");
  end

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  full_q, full_d;
  logic [SW-1:0]         s_q, s_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [15:0]           ucnt_q, ucnt_d;

  logic last_slot, x_last, y_last, pix_acc, load, starve;

  assign last_slot = (s_q == SW'(NSLOT - 1));
  assign x_last    = (x_q == XW'(H_ACTIVE - 1));
  assign y_last    = (y_q == YW'(V_ACTIVE - 1));
  assign pix_acc   = full_q && bus.pix_ready;

  // pix_ready feeds ready combinationally so the next word loads as the last slot leaves.
  assign bus.ready = !bus.resync && (!full_q || (pix_acc && last_slot));
  assign load      = bus.valid && bus.ready;
  assign starve    = bus.pix_ready && !full_q && (x_q != '0 || y_q != '0);

  assign bus.pix_valid    = full_q;
  assign bus.pix_data     = word_q[int'(s_q) * SLOT_WIDTH +: 24];
  assign bus.pix_sol      = full_q && (x_q == '0);
  assign bus.pix_eol      = full_q && x_last;
  assign bus.pix_sof      = full_q && (x_q == '0) && (y_q == '0);
  assign bus.pix_eof      = full_q && x_last && y_last;
  assign bus.underrun_cnt = ucnt_q;

  always_comb begin
    // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latches).
    word_d = word_q;
    full_d = full_q;
    s_d    = s_q;
    x_d    = x_q;
    y_d    = y_q;
    ucnt_d = ucnt_q;

    if (bus.resync) begin
      full_d = 1'b0;
      s_d    = '0;
      x_d    = '0;
      y_d    = '0;
    end else begin
      if (load) begin
        word_d = bus.st_data;
        s_d    = '0;
        full_d = 1'b1;
      end else if (pix_acc) begin
        if (last_slot) full_d = 1'b0;
        else           s_d    = s_q + 1'b1;
      end

      // Raster position follows accepted pixels only; word boundaries are irrelevant.
      if (pix_acc) begin
        if (x_last) begin
          x_d = '0;
          y_d = y_last ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end

      if (starve && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      full_q <= 1'b0;
      s_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      ucnt_q <= '0;
    end else begin
      word_q <= word_d;
      full_q <= full_d;
      s_q    <= s_d;
      x_q    <= x_d;
      y_q    <= y_d;
      ucnt_q <= ucnt_d;
    end
  end

endmodule

// File: tb/tb_st_pixel_unpacker.sv
// Scoreboard bench for st_pixel_unpacker on a small 4x3 raster.
// Expected pixels come from a raster-index model; a monitor checks every cycle.
module tb_st_pixel_unpacker;

  localparam int DW  = 256;
  localparam int SLW = 32;
  localparam int NS  = DW / SLW;
  localparam int H   = 4;
  localparam int V   = 3;
  localparam int FR  = H * V;

  typedef struct packed {
    logic [23:0] data;
    logic        sol;
    logic        eol;
    logic        sof;
    logic        eof;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  st_pixel_unpacker_if #(.DATA_WIDTH(DW)) bus ();

  st_pixel_unpacker #(
    .DATA_WIDTH(DW), .SLOT_WIDTH(SLW), .H_ACTIVE(H), .V_ACTIVE(V)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  pix_t exp_q[$];
  int   p_push, p_acc, exp_under;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ready_mode = 0;
  int   pat_idx = 0;
  logic stalled = 1'b0;
  pix_t snap, cur, e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pixels of a word, tagged from the running frame pixel index.
  function automatic void push_word(input logic [DW-1:0] w);
    for (int k = 0; k < NS; k++) begin
      pix_t px;
      int x, y;
      x = p_push % H;
      y = p_push / H;
      px.data = w[k*SLW +: 24];
      px.sol  = (x == 0);
      px.eol  = (x == H - 1);
      px.sof  = (p_push == 0);
      px.eof  = (p_push == FR - 1);
      exp_q.push_back(px);
      p_push = (p_push + 1) % FR;
    end
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < NS; k++) w[k*SLW +: SLW] = $urandom;
    return w;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      p_push = 0; p_acc = 0; exp_under = 0; stalled = 1'b0;
      continue;
    end
    cur = '{bus.pix_data, bus.pix_sol, bus.pix_eol, bus.pix_sof, bus.pix_eof};
    check("ready", bus.ready,
          !bus.resync && (exp_q.size() == 0 || (exp_q.size() == 1 && bus.pix_ready)));
    check("pix_valid", bus.pix_valid, exp_q.size() != 0);
    check("underrun_cnt", bus.underrun_cnt, exp_under);
    if (stalled) check("stall_hold", {bus.pix_valid, cur}, {1'b1, snap});
    if (bus.resync) begin
      exp_q.delete();
      p_push = 0; p_acc = 0; stalled = 1'b0;
    end else begin
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pixel", cur, e);
        end
        p_acc = (p_acc + 1) % FR;
      end else if (!bus.pix_valid && bus.pix_ready && p_acc != 0 && exp_under < 65535) begin
        exp_under++;
      end
      stalled = bus.pix_valid && !bus.pix_ready;
      snap    = cur;
      if (bus.valid && bus.ready) push_word(bus.st_data);
    end
  end

  // Downstream ready pattern generator.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       bus.pix_ready = 1'($urandom_range(0, 1));
      2:       begin bus.pix_ready = (pat_idx % 3 == 0); pat_idx++; end
      default: bus.pix_ready = 1'b1;
    endcase
  end

  task automatic send_word(input logic [DW-1:0] w);
    int t = 0;
    bus.st_data = w;
    bus.valid   = 1'b1;
    @(negedge clk);
    while (!bus.ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 bus.valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_resync();
    bus.resync = 1'b1;
    @(posedge clk);
    #1 bus.resync = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w;
    int cnt;
    bus.st_data = '0; bus.valid = 1'b0; bus.resync = 1'b0; bus.pix_ready = 1'b1;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_pix_valid", bus.pix_valid, 0);
    check("rst_pix_data", bus.pix_data, 0);
    check("rst_flags", {bus.pix_sol, bus.pix_eol, bus.pix_sof, bus.pix_eof}, 0);
    check("rst_underrun", bus.underrun_cnt, 0);
    @(posedge clk);
    #1;

    // One word, slot k = 0xFF00000k, full-rate drain.
    for (int k = 0; k < NS; k++) w[k*SLW +: SLW] = 32'hFF00_0000 | k;
    send_word(w);
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      check("t1_pix_valid", bus.pix_valid, 1);
      check("t1_ready", bus.ready, i == NS - 1);
      check("t1_pix_data", bus.pix_data, i);
    end

    // Stream now sits mid-frame: starvation is counted, then saturates.
    @(negedge clk);
    check("t4_idle", bus.pix_valid, 0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 check("t4_underrun_10", bus.underrun_cnt, 10);
    repeat (65600) @(posedge clk);
    #1 check("t4_underrun_sat", bus.underrun_cnt, 16'hFFFF);

    pulse_resync();
    check("t5_resync_keeps_underrun", bus.underrun_cnt, 16'hFFFF);

    // Four words back-to-back, no bubbles allowed.
    cnt = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_word(rand_word());
      end
      begin
        int t = 0;
        @(negedge clk);
        while (!bus.pix_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        for (int i = 0; i < 4 * NS; i++) begin
          if (bus.pix_valid) cnt++;
          @(negedge clk);
        end
      end
    join
    check("t2_no_bubble", cnt, 4 * NS);
    drain("t2_drain");

    // Backpressure pattern 1,0,0 during one word.
    pat_idx = 0;
    ready_mode = 2;
    send_word(rand_word());
    drain("t3_drain");
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Resync after three pixels of a word.
    send_word(rand_word());
    repeat (3) @(posedge clk);
    #1;
    bus.resync  = 1'b1;
    bus.st_data = rand_word();
    bus.valid   = 1'b1;
    #1 check("t5_ready_in_resync", bus.ready, 0);
    @(posedge clk);
    #1 bus.resync = 1'b0;
    check("t5_valid_dropped", bus.pix_valid, 0);
    @(posedge clk);
    #1 bus.valid = 1'b0;
    check("t5_first_after_resync", {bus.pix_valid, bus.pix_sof, bus.pix_sol}, 3'b111);
    drain("t5_drain");

    // Asynchronous reset in the middle of a word.
    send_word(rand_word());
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_pix_valid", bus.pix_valid, 0);
    check("t6_ready", bus.ready, 1);
    check("t6_underrun", bus.underrun_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(rand_word());
    @(negedge clk);
    check("t6_first_after_reset", {bus.pix_valid, bus.pix_sof, bus.pix_sol}, 3'b111);
    drain("t6_drain");

    // Randomized traffic with random downstream stalls, gaps and resyncs.
    ready_mode = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ($urandom_range(0, 9) == 0) pulse_resync();
      send_word(rand_word());
    end
    drain("rand_drain");
    ready_mode = 0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
